dram16_rd_deser: RTL and testbench

Read-back deserializer between the 16 DRAM macros' parallel-to-serial output shift registers and the read controller. It drives the external shift-register controls (`PC_data`), loads the 16 chips' 8-bit read results in parallel, and shifts them in MSB-first on `DRAM16_data[16:1]`. It then presents 16 assembled bytes with a one-cycle `RD_DONE` strobe.

---
 rtl/dram16_rd_deser.sv | 185 ++++++++++++++++++
 tb/tb_dram16_rd_deser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram16_rd_deser.sv
// dram16_rd_deser: drives the 16 DRAM output shift registers and assembles their MSB-first bytes.
// Optional feature: define DRAM16_RD_DESER_MAJ3_EN to vote each bit from three samples.
module dram16_rd_deser #(
    parameter int DIV   = 4,
    parameter int LANES = 16,
    parameter int BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RD_START,
    input  logic [LANES:1]        DRAM16_data,
    output logic [2:0]            PC_data,
    output logic                  RD_BUSY,
    output logic                  RD_DONE,
    output logic [LANES*BITS-1:0] DATA_OUT
);

    localparam int                 BIT_W      = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [7:0]         PHASE_LAST = 8'(DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS - 1);

`ifdef DRAM16_RD_DESER_MAJ3_EN
    localparam int MIN_DIV = 3;
`else
    localparam int MIN_DIV = 2;
`endif

    if (DIV < MIN_DIV) begin : g_divCheck
        $error("dram16_rd_deser: DIV=%0d is below the minimum of %0d", DIV, MIN_DIV);
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT,
        DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [7:0]                     phaseCnt_q, phaseCnt_d;
    logic [BIT_W-1:0]               bitCnt_q, bitCnt_d;
    logic                           highPhase_q, highPhase_d;
    logic [LANES-1:0][BITS-1:0]     laneReg_q, laneReg_d;
    logic [2:0]                     pcData_q, pcData_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [LANES*BITS-1:0]          dataOut_q, dataOut_d;
    logic [LANES-1:0]               laneBit;
    logic                           phaseEnd;
    logic                           sampleEn;

    assign phaseEnd = (phaseCnt_q == PHASE_LAST);
    assign sampleEn = (state_q == SHIFT) && !highPhase_q && phaseEnd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phaseCnt_q  <= '0;
            bitCnt_q    <= '0;
            highPhase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phaseCnt_q  <= phaseCnt_d;
            bitCnt_q    <= bitCnt_d;
            highPhase_q <= highPhase_d;
        end
    end

    // Each bit is a DIV-cycle low phase (sampled at its end) followed by a high phase, except the last bit.
    always_comb begin
        state_d     = state_q;
        phaseCnt_d  = phaseCnt_q + 8'd1;
        bitCnt_d    = bitCnt_q;
        highPhase_d = highPhase_q;
        unique case (state_q)
            IDLE: begin
                phaseCnt_d = '0;
                if (RD_START) begin
                    state_d     = LOAD;
                    bitCnt_d    = '0;
                    highPhase_d = 1'b0;
                end
            end
            LOAD: begin
                if (phaseEnd) begin
                    state_d    = SETTLE;
                    phaseCnt_d = '0;
                end
            end
            SETTLE: begin
                if (phaseEnd) begin
                    state_d     = SHIFT;
                    phaseCnt_d  = '0;
                    highPhase_d = 1'b0;
                end
            end
            SHIFT: begin
                if (phaseEnd) begin
                    phaseCnt_d = '0;
                    if (highPhase_q) begin
                        highPhase_d = 1'b0;
                        bitCnt_d    = bitCnt_q + BIT_W'(1);
                    end else if (bitCnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        highPhase_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                phaseCnt_d = '0;
            end
            default: begin
                state_d    = IDLE;
                phaseCnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave registers aligned with the state.
    always_comb begin
        pcData_d = 3'b110;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        unique case (state_d)
            LOAD:    pcData_d = 3'b100;
            SETTLE:  pcData_d = 3'b010;
            SHIFT:   pcData_d = {2'b01, highPhase_d};
            default: pcData_d = 3'b110;
        endcase
    end

`ifdef DRAM16_RD_DESER_MAJ3_EN
    logic [LANES-1:0] hist1_q;
    logic [LANES-1:0] hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= '0;
            hist2_q <= '0;
        end else begin
            hist1_q <= DRAM16_data;
            hist2_q <= hist1_q;
        end
    end

    assign laneBit = (DRAM16_data & hist1_q) | (DRAM16_data & hist2_q) | (hist1_q & hist2_q);
`else
    assign laneBit = DRAM16_data;
`endif

    always_comb begin
        laneReg_d = laneReg_q;
        if (sampleEn) begin
            for (int k = 0; k < LANES; k++) begin
                laneReg_d[k] = {laneReg_q[k][BITS-2:0], laneBit[k]};
            end
        end
        dataOut_d = done_d ? laneReg_d : dataOut_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            laneReg_q <= '0;
            pcData_q  <= 3'b110;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dataOut_q <= '0;
        end else begin
            laneReg_q <= laneReg_d;
            pcData_q  <= pcData_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dataOut_q <= dataOut_d;
        end
    end

    assign PC_data  = pcData_q;
    assign RD_BUSY  = busy_q;
    assign RD_DONE  = done_q;
    assign DATA_OUT = dataOut_q;

endmodule

// File: tb/tb_dram16_rd_deser.sv
// tb_dram16_rd_deser: scoreboard bench for dram16_rd_deser driving a model of the 16 chips' shift registers.
`timescale 1ns/1ps
module tb_dram16_rd_deser;

    localparam int DIV      = 4;
    localparam int DONE_LAT = 17 * DIV + 1;

    typedef struct {
        logic [127:0] data;
        int           doneEdge;
        int           riseBase;
        int           loadBase;
    } sbEntry_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         RD_START;
    logic [16:1]  DRAM16_data;
    logic [2:0]   PC_data;
    logic         RD_BUSY;
    logic         RD_DONE;
    logic [127:0] DATA_OUT;

    logic [7:0]   pre   [1:16];
    logic [7:0]   shreg [1:16];
    logic [16:1]  glitch;

    int           edgeCnt = 0;
    int           assertCnt;
    int           failCnt;
    int           riseTotal;
    int           loadTotal;
    int           lastStart;
    logic         prevPc0;
    sbEntry_t     sbQ[$];
    sbEntry_t     popped;
    logic [127:0] expData;

    dram16_rd_deser #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RD_START    (RD_START),
        .DRAM16_data (DRAM16_data),
        .PC_data     (PC_data),
        .RD_BUSY     (RD_BUSY),
        .RD_DONE     (RD_DONE),
        .DATA_OUT    (DATA_OUT)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // Parallel load while SR/LD# is low, shift toward QH on shift-clock rise unless inhibited.
    always @(posedge PC_data[0] or negedge PC_data[1]) begin
        if (!PC_data[1]) begin
            for (int k = 1; k <= 16; k++) shreg[k] <= pre[k];
        end else if (!PC_data[2]) begin
            for (int k = 1; k <= 16; k++) shreg[k] <= {shreg[k][6:0], 1'b0};
        end
    end

    always_comb begin
        DRAM16_data = '0;
        for (int k = 1; k <= 16; k++) DRAM16_data[k] = shreg[k][7] ^ glitch[k];
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] packPre();
        logic [127:0] r;
        r = '0;
        for (int k = 1; k <= 16; k++) r[8*k-1 -: 8] = pre[k];
        return r;
    endfunction

    task automatic applyStimulus(input logic accept, input logic [127:0] expected);
        sbEntry_t e;
        RD_START = 1'b1;
        if (accept) begin
            lastStart  = edgeCnt;
            e.data     = expected;
            e.doneEdge = edgeCnt + DONE_LAT;
            e.riseBase = riseTotal;
            e.loadBase = loadTotal;
            sbQ.push_back(e);
        end
        nextCycle();
        RD_START = 1'b0;
    endtask

    task automatic waitCycle(input int c);
        while (edgeCnt < lastStart + c) nextCycle();
    endtask

    task automatic waitDrained();
        for (int i = 0; i < 400 && sbQ.size() != 0; i++) nextCycle();
        checkOutput("drain", 128'(sbQ.size()), 128'd0);
    endtask

    task automatic randomPre();
        for (int k = 1; k <= 16; k++) pre[k] = 8'($urandom);
    endtask

    initial begin
        assertCnt = 0;
        failCnt   = 0;
        riseTotal = 0;
        loadTotal = 0;
        lastStart = 0;
        prevPc0   = 1'b0;
        RD_START  = 1'b0;
        glitch    = '0;
        rst_n     = 1'b0;
        for (int k = 1; k <= 16; k++) pre[k] = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (PC_data[0] && !prevPc0) riseTotal++;
                if (!PC_data[1]) loadTotal++;
                prevPc0 = PC_data[0];
                if (RD_DONE) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_done", 128'd1, 128'd0);
                    end else begin
                        popped = sbQ.pop_front();
                        checkOutput("data", DATA_OUT, popped.data);
                        checkOutput("done_cycle", 128'(edgeCnt), 128'(popped.doneEdge));
                        checkOutput("pc_rises", 128'(riseTotal - popped.riseBase), 128'd7);
                        checkOutput("load_width", 128'(loadTotal - popped.loadBase), 128'(DIV));
                    end
                end
            end
        join_none

        repeat (3) nextCycle();
        checkOutput("rst_pc", 128'(PC_data), 128'(3'b110));
        checkOutput("rst_busy", 128'(RD_BUSY), 128'd0);
        checkOutput("rst_done", 128'(RD_DONE), 128'd0);
        checkOutput("rst_data", DATA_OUT, 128'd0);
        rst_n = 1'b1;
        repeat (2) nextCycle();

        $display("[TB] single read");
        for (int k = 1; k <= 16; k++) pre[k] = 8'(8'h10 + k - 1);
        applyStimulus(1'b1, packPre());
        waitDrained();
        checkOutput("single_value", DATA_OUT, 128'h1F1E1D1C1B1A19181716151413121110);
        checkOutput("idle_pc", 128'(PC_data), 128'(3'b110));

        $display("[TB] pattern read");
        for (int k = 1; k <= 16; k++) pre[k] = (k % 2 == 1) ? 8'hA5 : 8'h5A;
        applyStimulus(1'b1, packPre());
        waitDrained();
        checkOutput("pattern_value", DATA_OUT, 128'h5AA55AA55AA55AA55AA55AA55AA55AA5);

        $display("[TB] busy rejection");
        randomPre();
        expData = packPre();
        applyStimulus(1'b1, expData);
        checkOutput("busy_c1", 128'(RD_BUSY), 128'd1);
        waitCycle(20);
        applyStimulus(1'b0, 128'd0);
        waitCycle(69);
        checkOutput("busy_c69", 128'(RD_BUSY), 128'd1);
        checkOutput("done_c69", 128'(RD_DONE), 128'd1);
        applyStimulus(1'b0, 128'd0);
        checkOutput("busy_c70", 128'(RD_BUSY), 128'd0);
        checkOutput("done_c70", 128'(RD_DONE), 128'd0);
        repeat (100) nextCycle();
        checkOutput("busy_after", 128'(RD_BUSY), 128'd0);
        checkOutput("data_hold", DATA_OUT, expData);
        checkOutput("busy_drain", 128'(sbQ.size()), 128'd0);

        $display("[TB] reset mid-read");
        randomPre();
        applyStimulus(1'b1, packPre());
        waitCycle(30);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pc", 128'(PC_data), 128'(3'b110));
        checkOutput("midrst_busy", 128'(RD_BUSY), 128'd0);
        checkOutput("midrst_done", 128'(RD_DONE), 128'd0);
        checkOutput("midrst_data", DATA_OUT, 128'd0);
        sbQ.delete();
        repeat (2) nextCycle();
        rst_n = 1'b1;
        repeat (2) nextCycle();
        checkOutput("postrst_busy", 128'(RD_BUSY), 128'd0);
        randomPre();
        applyStimulus(1'b1, packPre());
        waitDrained();

        $display("[TB] glitch on lane 3, bit 4");
        randomPre();
        pre[3] = 8'h3C;
        expData = packPre();
`ifndef DRAM16_RD_DESER_MAJ3_EN
        expData[19] = ~expData[19];
`endif
        applyStimulus(1'b1, expData);
        waitCycle(44);
        glitch[3] = 1'b1;
        nextCycle();
        glitch[3] = 1'b0;
        waitDrained();

        $display("[TB] back-to-back and random reads");
        randomPre();
        applyStimulus(1'b1, packPre());
        waitCycle(70);
        randomPre();
        applyStimulus(1'b1, packPre());
        waitDrained();
        for (int n = 0; n < 3; n++) begin
            randomPre();
            applyStimulus(1'b1, packPre());
            waitDrained();
            repeat (3) nextCycle();
        end

        repeat (5) nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
